// File: rtl/jtag_tdo_capture_if.sv
// Readback FIFO write port between the TDO capture monitor and the FIFO.
// Signals: wdata (captured word), wr (write strobe), full (FIFO full).
interface jtag_tdo_capture_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] wdata;
    logic              wr;
    logic              full;

    modport master (
        output wdata,
        output wr,
        input  full
    );

    modport slave (
        input  wdata,
        input  wr,
        output full
    );
endinterface

// File: rtl/jtag_tdo_capture.sv
// Passive JTAG monitor: tracks the TAP state and packs tdo bits seen in
// SHIFT-DR (optionally SHIFT-IR) into MSB-first words for the readback FIFO.
// Ports: clk, rst (sync, active high), tck/tms/tdo (JTAG lines, clk domain),
//   fifo (wdata/wr/full write port), overflow/ovf_clr (sticky drop flag),
//   tap_state (current TAP state), shifting (in a capturing shift state).
module jtag_tdo_capture #(
    parameter int DATA_W     = 8,
    parameter bit CAPTURE_IR = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tck,
    input  logic                      tms,
    input  logic                      tdo,
    jtag_tdo_capture_if.master        fifo,
    output logic                      overflow,
    input  logic                      ovf_clr,
    output logic [3:0]                tap_state,
    output logic                      shifting
);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);

    typedef enum logic [3:0] {
        TLR   = 4'd0,
        RTI   = 4'd1,
        SELDR = 4'd2,
        CAPDR = 4'd3,
        SHDR  = 4'd4,
        EX1DR = 4'd5,
        PSDR  = 4'd6,
        EX2DR = 4'd7,
        UPDR  = 4'd8,
        SELIR = 4'd9,
        CAPIR = 4'd10,
        SHIR  = 4'd11,
        EX1IR = 4'd12,
        PSIR  = 4'd13,
        EX2IR = 4'd14,
        UPIR  = 4'd15
    } tap_t;

    tap_t              state;
    tap_t              state_n;
    logic              tck_q;
    logic              rise;
    logic              cap_st;
    logic              up_entry;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_n;
    logic [DATA_W-1:0] flush_word;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] held;
    logic              pend;

    assign rise      = tck & ~tck_q;
    assign tap_state = state;
    assign cap_st    = (state == SHDR) || (CAPTURE_IR && (state == SHIR));
    assign shifting  = cap_st;

    // A partial word is only flushed once the shift really ends (entering
    // UPDATE); the exit-1 edge alone may still lead back via PAUSE/EXIT2.
    assign up_entry  = (state_n == UPDR) || (state_n == UPIR);

    always_comb begin
        state_n = state;
        unique case (state)
            TLR:   state_n = tms ? TLR   : RTI;
            RTI:   state_n = tms ? SELDR : RTI;
            SELDR: state_n = tms ? SELIR : CAPDR;
            CAPDR: state_n = tms ? EX1DR : SHDR;
            SHDR:  state_n = tms ? EX1DR : SHDR;
            EX1DR: state_n = tms ? UPDR  : PSDR;
            PSDR:  state_n = tms ? EX2DR : PSDR;
            EX2DR: state_n = tms ? UPDR  : SHDR;
            UPDR:  state_n = tms ? SELDR : RTI;
            SELIR: state_n = tms ? TLR   : CAPIR;
            CAPIR: state_n = tms ? EX1IR : SHIR;
            SHIR:  state_n = tms ? EX1IR : SHIR;
            EX1IR: state_n = tms ? UPIR  : PSIR;
            PSIR:  state_n = tms ? EX2IR : PSIR;
            EX2IR: state_n = tms ? UPIR  : SHIR;
            UPIR:  state_n = tms ? SELDR : RTI;
            default: state_n = TLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TLR;
        end else if (rise) begin
            state <= state_n;
        end
    end

    always_comb begin
        sreg_n     = {sreg[DATA_W-2:0], tdo};
        cnt_n      = cnt + 1'b1;
        flush_word = sreg << (DATA_W - int'(cnt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tck_q    <= tck;
            sreg     <= '0;
            cnt      <= '0;
            word     <= '0;
            held     <= '0;
            pend     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tck_q <= tck;
            pend  <= 1'b0;

            if (pend && !fifo.full) begin
                held <= word;
            end

            if (pend && fifo.full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            if (rise) begin
                if (cap_st) begin
                    if (cnt_n == CNT_FULL) begin
                        word <= sreg_n;
                        pend <= 1'b1;
                        cnt  <= '0;
                        sreg <= '0;
                    end else begin
                        sreg <= sreg_n;
                        cnt  <= cnt_n;
                    end
                end else if (up_entry && (cnt != '0)) begin
                    word <= flush_word;
                    pend <= 1'b1;
                    cnt  <= '0;
                    sreg <= '0;
                end
            end
        end
    end

    // wdata shows the pending word in its write cycle and otherwise holds
    // the last word actually accepted by the FIFO.
    assign fifo.wr    = pend & ~fifo.full;
    assign fifo.wdata = pend ? word : held;
endmodule

// File: tb/tb_jtag_tdo_capture.sv
// Directed bench for jtag_tdo_capture: TAP walk, word packing, flush,
// pause detour, overflow and mid-shift reset.
module tb_jtag_tdo_capture;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tck = 1'b0;
    logic       tms = 1'b0;
    logic       tdo = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       overflow;
    logic [3:0] tap_state;
    logic       shifting;

    int checks = 0;
    int errors = 0;
    logic [7:0] wq[$];
    int base;

    jtag_tdo_capture_if #(.DATA_W(8)) fifo ();

    jtag_tdo_capture #(.DATA_W(8), .CAPTURE_IR(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .tck       (tck),
        .tms       (tms),
        .tdo       (tdo),
        .fifo      (fifo.master),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .tap_state (tap_state),
        .shifting  (shifting)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fifo.wr) wq.push_back(fifo.wdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic m, input logic d);
        @(posedge clk); #1;
        tck = 1'b1; tms = m; tdo = d;
        @(posedge clk); #1;
        tck = 1'b0;
    endtask

    task automatic to_shdr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // n bits, bits[n-1] first; tms=1 on the last bit when ex is set
    task automatic shift_bits(input logic [15:0] bits, input int n,
                              input bit ex);
        for (int i = n - 1; i >= 0; i--) begin
            tick((ex && i == 0) ? 1'b1 : 1'b0, bits[i]);
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        fifo.full = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tap", 32'(tap_state), 32'd0);
        chk("rst_wr", 32'(fifo.wr), 32'd0);
        chk("rst_wdata", 32'(fifo.wdata), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_shift", 32'(shifting), 32'd0);

        // TAP walk and return to TLR
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("t1_capdr", 32'(tap_state), 32'd3);
        repeat (5) tick(1'b1, 1'b0);
        chk("t1_tlr", 32'(tap_state), 32'd0);
        tick(1'b0, 1'b0);
        chk("t1_rti", 32'(tap_state), 32'd1);

        // single full word A5
        to_shdr();
        chk("t2_shdr", 32'(tap_state), 32'd4);
        chk("t2_shifting", 32'(shifting), 32'd1);
        base = wq.size();
        shift_bits(16'h00A5, 8, 1'b1);
        chk("t2_wr_timing", 32'(fifo.wr), 32'd1);
        chk("t2_wdata", 32'(fifo.wdata), 32'hA5);
        settle();
        chk("t2_wr_once", 32'(fifo.wr), 32'd0);
        chk("t2_ex1dr", 32'(tap_state), 32'd5);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        settle();
        chk("t2_count", 32'(wq.size() - base), 32'd1);
        chk("t2_hold", 32'(fifo.wdata), 32'hA5);

        // 12 ones: full word then left-justified partial flush
        to_shdr();
        base = wq.size();
        shift_bits(16'h0FFF, 12, 1'b1);
        chk("t3_ex1dr", 32'(tap_state), 32'd5);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        settle();
        chk("t3_count", 32'(wq.size() - base), 32'd2);
        if (wq.size() - base == 2) begin
            chk("t3_word0", 32'(wq[base]), 32'hFF);
            chk("t3_word1", 32'(wq[base+1]), 32'hF0);
        end

        // pause detour keeps the partial word
        to_shdr();
        base = wq.size();
        shift_bits(16'h0019, 5, 1'b1);
        tick(1'b0, 1'b0);
        chk("t4_psdr", 32'(tap_state), 32'd6);
        tick(1'b1, 1'b0);
        chk("t4_ex2dr", 32'(tap_state), 32'd7);
        tick(1'b0, 1'b0);
        chk("t4_shdr", 32'(tap_state), 32'd4);
        chk("t4_no_wr", 32'(wq.size() - base), 32'd0);
        shift_bits(16'h0003, 3, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        settle();
        chk("t4_count", 32'(wq.size() - base), 32'd1);
        chk("t4_wdata", 32'(fifo.wdata), 32'hCB);

        // overflow on full, then clear
        to_shdr();
        base = wq.size();
        fifo.full = 1'b1;
        shift_bits(16'h003C, 8, 1'b1);
        settle();
        fifo.full = 1'b0;
        chk("t5_no_wr", 32'(wq.size() - base), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd1);
        chk("t5_wdata_kept", 32'(fifo.wdata), 32'hCB);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        chk("t5_ovf_clr", 32'(overflow), 32'd0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // reset mid-shift discards partial word
        to_shdr();
        base = wq.size();
        shift_bits(16'h000F, 4, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        settle();
        chk("t6_tap", 32'(tap_state), 32'd0);
        chk("t6_no_wr", 32'(wq.size() - base), 32'd0);
        tick(1'b0, 1'b0);
        to_shdr();
        shift_bits(16'h005A, 8, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        settle();
        chk("t6_count", 32'(wq.size() - base), 32'd1);
        chk("t6_wdata", 32'(fifo.wdata), 32'h5A);

        // tck held high: only the single rise counts
        @(posedge clk); #1 tck = 1'b1; tms = 1'b1;
        repeat (4) begin
            @(posedge clk); #1 tms = ~tms;
        end
        tck = 1'b0;
        settle();
        chk("t7_frozen", 32'(tap_state), 32'd2);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("t7_tlr", 32'(tap_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
